serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes D = A - B one bit per clock, LSB first, using a full-subtractor cell and a registered borrow.
- Subtraction counterpart to the team's ripple adder built from half-adder cells.
- Sits in the lab datapath beside the adder and trades latency for one-bit-wide logic.
- Start/busy/done handshake; the result holds until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values 1 to 32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a subtraction; sampled on the rising edge of clk.
- A  input  WIDTH  minuend; sampled only on the accepting edge.
- B  input  WIDTH  subtrahend; sampled only on the accepting edge.
- busy  output  1  high while the serial operation is in progress.
- done  output  1  one-cycle pulse; D, Bout and V are valid from this cycle.
- D  output  WIDTH  difference A - B, modulo 2^WIDTH.
- Bout  output  1  final borrow; 1 iff A < B unsigned.
- V  output  1  two's-complement overflow of A - B.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state, while rst_n = 0:
  - FSM in IDLE.
  - busy = 0, done = 0, D = 0, Bout = 0, V = 0.
  - Shift registers, borrow register and bit counter all cleared.
  - Reset takes effect immediately, including mid-operation; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at edge k → latch A and B into shift registers, clear borrow, counter = 0, go to SHIFT.
  - busy = 1 from edge k.
- SHIFT, once per edge:
  - a = A_sh[0], b = B_sh[0].
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - Shift A_sh and B_sh right by one.
  - Shift the internal result register right, inserting d at the MSB.
  - counter increments.
- SHIFT exit:
  - The edge that performs bit WIDTH-1 is edge k+WIDTH.
  - At that edge go to DONE and load D from the result register, including the final bit.
  - Bout = br_next of the final bit.
  - V = (A_msb ^ B_msb) & (D_msb ^ A_msb), using the latched operand MSBs.
  - busy = 0, done = 1.
- Latency: done is high for exactly the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accepting edge. No pipelining; one operation at a time.
- DONE:
  - Lasts one cycle.
  - Next edge goes to IDLE, or to SHIFT if start = 1 on that edge (back-to-back accept, same latching as IDLE).
  - done drops on that edge in either case.
- start while in SHIFT: ignored. No queuing; operands are not re-sampled.
- Operand stability: A and B may change freely after the accepting edge.
- Output holding: D, Bout and V change only on entry to DONE (or on reset). They keep the previous result throughout a new operation.
- Counter width: clog2(WIDTH+1) bits. No wrap-around within an operation.
- WIDTH = 1: a single SHIFT edge; done follows one cycle after accept.

Test Plan (WIDTH = 8):
- rst_n low, then high; start = 1 with A = 100, B = 37 → busy high 8 cycles; done one cycle; D = 63 (8'h3F), Bout = 0, V = 0.
- A = 5, B = 9 → D = 8'hFC, Bout = 1, V = 0.
- A = 8'h80, B = 8'h01 → D = 8'h7F, Bout = 0, V = 1. Then A = 8'h7F, B = 8'hFF → D = 8'h80, Bout = 1, V = 1.
- Start with A = 200, B = 50, then pulse start with A = 1, B = 1 during busy → second start ignored; D = 150 (8'h96), Bout = 0. Hold start high in the done cycle with A = 0, B = 0 → new operation accepted; D = 0 eight cycles later.
- Start A = 9, B = 3; assert rst_n = 0 after 4 SHIFT edges → busy, done, D, Bout and V are 0 immediately. Release rst_n; start A = 9, B = 3 → D = 6 after 8 cycles.
- A = B = 0 → D = 0, Bout = 0, V = 0. Previous D holds unchanged during busy until the done cycle.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, with a registered borrow
// and a start/busy/done handshake; results hold until the next op completes.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, r, r_next;
   logic [CW-1:0] cnt;
   logic br, a_msb, b_msb, a0, b0, d, br_next, last;
   always_comb begin
      a0      = a_sh[0];
      b0      = b_sh[0];
      d       = a0 ^ b0 ^ br;
      br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
      r_next  = (r >> 1) | (WIDTH'(d) << (WIDTH - 1));
      last    = cnt == CW'(WIDTH - 1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         D     <= '0;
         Bout  <= 1'b0;
         V     <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         r     <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  a_msb <= A[WIDTH-1];
                  b_msb <= B[WIDTH-1];
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r    <= r_next;
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               // the final bit lands in D directly, so the result is ready with done
               if (last) begin
                  D     <= r_next;
                  Bout  <= br_next;
                  V     <= (a_msb ^ b_msb) & (d ^ a_msb);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations checked against an
// arithmetic model of A - B, including handshake timing and result holding.
module tb_serial_subtractor;
   localparam int WIDTH = 8;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [WIDTH-1:0] A = '0, B = '0;
   logic busy, done, Bout, V;
   logic [WIDTH-1:0] D;
   int n_checks = 0, n_fail = 0;
   logic [WIDTH-1:0] prev_d = '0;
   logic prev_b = 1'b0, prev_v = 1'b0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .D(D), .Bout(Bout), .V(V)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      start = 1'b1;
      A = a;
      B = b;
   endtask

   task automatic finish_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit glitch);
      logic [WIDTH-1:0] ed;
      logic eb, ev;
      int diff;
      ed   = a - b;
      eb   = a < b;
      diff = int'($signed(a)) - int'($signed(b));
      ev   = diff > 127 || diff < -128;
      @(negedge clk);
      start = 1'b0;
      A = WIDTH'($urandom);
      B = WIDTH'($urandom);
      for (int j = 0; j < WIDTH; j++) begin
         check("busy_high", busy, 1);
         check("done_low", done, 0);
         check("d_hold", D, prev_d);
         check("bout_hold", Bout, prev_b);
         check("v_hold", V, prev_v);
         start = glitch && j == 3;
         if (start) begin
            A = 1;
            B = 1;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_pulse", done, 1);
      check("busy_low", busy, 0);
      check("diff", D, ed);
      check("borrow", Bout, eb);
      check("overflow", V, ev);
      prev_d = ed;
      prev_b = eb;
      prev_v = ev;
   endtask

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit glitch);
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      start_op(a, b);
      finish_op(a, b, glitch);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_d", D, 0);
      check("rst_bout", Bout, 0);
      check("rst_v", V, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_op(100, 37, 0);
      do_op(5, 9, 0);
      do_op(8'h80, 8'h01, 0);
      do_op(8'h7F, 8'hFF, 0);
      do_op(200, 50, 1);
      start_op(0, 0);
      finish_op(0, 0, 0);
      // abort an operation midway with reset
      @(negedge clk);
      start_op(9, 3);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_d", D, 0);
      check("mid_rst_bout", Bout, 0);
      check("mid_rst_v", V, 0);
      prev_d = '0;
      prev_b = 1'b0;
      prev_v = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(9, 3, 0);
      do_op(0, 0, 0);
      for (int i = 0; i < 30; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         if ($urandom_range(3) == 0) begin
            start_op(ra, rb);
            finish_op(ra, rb, $urandom_range(1) == 1);
         end else begin
            do_op(ra, rb, $urandom_range(1) == 1);
         end
      end
      @(negedge clk);
      check("final_done", done, 0);
      check("final_d", D, prev_d);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
